// File: rtl/seg7_scan_driver_if.sv
// Host/display bundle for the multiplexed 7-segment driver.
// The host side (master) supplies digit data and the load strobe.
// The driver side (slave) returns the segment, decimal-point, anode and frame-tick pins.
`timescale 1ns/1ps

interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en;
  logic                    load;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_tick;

  modport master (
    output value_in, dp_in, blank_in, lz_en, load,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  value_in, dp_in, blank_in, lz_en, load,
    output seg_out, dp_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver.
// The host writes a staging buffer at any time; staged data moves to the displayed
// (shadow) buffer only at a frame boundary, so a frame never shows mixed data.
// One digit is driven per slot of REFRESH_DIV cycles; all pins are registered and
// change only when the digit index advances (plus the first edge after reset).
`timescale 1ns/1ps

module seg7_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  // Pin levels meaning "dark" / "no digit selected" for the chosen polarities.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  // Hex to segment pattern in active-low form, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_to_seg_al(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h01;
      4'h1: pat = 7'h4F;
      4'h2: pat = 7'h12;
      4'h3: pat = 7'h06;
      4'h4: pat = 7'h4C;
      4'h5: pat = 7'h24;
      4'h6: pat = 7'h20;
      4'h7: pat = 7'h0F;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h04;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h60;
      4'hC: pat = 7'h31;
      4'hD: pat = 7'h42;
      4'hE: pat = 7'h30;
      default: pat = 7'h38;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------- scan timing
  logic [CNT_W-1:0] div_cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic             tick;
  logic             boundary;

  assign tick     = (div_cnt_reg == LAST_CNT);
  assign boundary = tick && (idx_reg == LAST_IDX);
  assign idx_next = !tick ? idx_reg
                  : (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

  // Prescaler and digit index: one slot per REFRESH_DIV cycles, wrapping over all digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      idx_reg     <= '0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + CNT_W'(1);
      idx_reg     <= idx_next;
    end
  end

  // ---------------------------------------------------------------- double buffer
  logic [4*NUM_DIGITS-1:0] stage_value_reg;
  logic [NUM_DIGITS-1:0]   stage_dp_reg;
  logic [NUM_DIGITS-1:0]   stage_blank_reg;
  logic                    stage_lz_reg;
  logic                    pending_reg;

  logic [4*NUM_DIGITS-1:0] shadow_value_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_blank_reg;
  logic                    shadow_lz_reg;

  logic                    commit;
  logic [4*NUM_DIGITS-1:0] shadow_value_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_next;
  logic [NUM_DIGITS-1:0]   shadow_blank_next;
  logic                    shadow_lz_next;

  // The pre-edge staging content is what commits, so a load on the boundary cycle
  // itself waits for the following frame.
  assign commit            = boundary && pending_reg;
  assign shadow_value_next = commit ? stage_value_reg : shadow_value_reg;
  assign shadow_dp_next    = commit ? stage_dp_reg    : shadow_dp_reg;
  assign shadow_blank_next = commit ? stage_blank_reg : shadow_blank_reg;
  assign shadow_lz_next    = commit ? stage_lz_reg    : shadow_lz_reg;

  // Staging capture on load, shadow transfer at a frame boundary when data is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_value_reg  <= '0;
      stage_dp_reg     <= '0;
      stage_blank_reg  <= '0;
      stage_lz_reg     <= 1'b0;
      pending_reg      <= 1'b0;
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      shadow_blank_reg <= '0;
      shadow_lz_reg    <= 1'b0;
    end else begin
      if (bus.load) begin
        stage_value_reg <= bus.value_in;
        stage_dp_reg    <= bus.dp_in;
        stage_blank_reg <= bus.blank_in;
        stage_lz_reg    <= bus.lz_en;
      end
      if (bus.load) begin
        pending_reg <= 1'b1;
      end else if (boundary) begin
        pending_reg <= 1'b0;
      end
      shadow_value_reg <= shadow_value_next;
      shadow_dp_reg    <= shadow_dp_next;
      shadow_blank_reg <= shadow_blank_next;
      shadow_lz_reg    <= shadow_lz_next;
    end
  end

  // ---------------------------------------------------------------- per-digit decode
  // Everything below is computed from the post-edge shadow so the digit driven
  // right after a boundary already shows the newly committed frame.
  logic [NUM_DIGITS-1:0] zero_from;
  logic [3:0]            nib     [NUM_DIGITS];
  logic [6:0]            lit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lit_dp;
  logic [NUM_DIGITS-1:0] lz_dark;

  // zero_from[k]: nibble k and every more significant nibble are zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (shadow_value_next[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (shadow_value_next[4*k +: 4] == 4'h0);
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = shadow_value_next[4*gi +: 4];

    // The least significant digit always shows, so a value of zero reads "0".
    if (gi == 0) begin : g_lsd
      assign lz_dark[gi] = 1'b0;
    end else begin : g_upper
      assign lz_dark[gi] = shadow_lz_next && zero_from[gi];
    end

    // Active-high "lit" form; polarity is applied once at the output mux.
    assign lit_seg[gi] = (shadow_blank_next[gi] || lz_dark[gi]) ? 7'h00
                                                                 : ~hex_to_seg_al(nib[gi]);
    assign lit_dp[gi]  = shadow_dp_next[gi] && !shadow_blank_next[gi];
  end

  // ---------------------------------------------------------------- output pins
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_hot;
  logic [NUM_DIGITS-1:0] an_next;

  // Select the digit addressed by the post-edge index and apply pin polarities.
  always_comb begin
    an_hot          = '0;
    an_hot[idx_next] = 1'b1;
    seg_next = (SEG_ACTIVE_LOW != 0) ? ~lit_seg[idx_next] : lit_seg[idx_next];
    dp_next  = (SEG_ACTIVE_LOW != 0) ? ~lit_dp[idx_next]  : lit_dp[idx_next];
    an_next  = (ANODE_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
  end

  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic                  frame_tick_reg;
  logic                  active_reg;

  // Registered pins: refreshed when the index advances, and once right after reset
  // so digit 0 lights on the first edge; frame_tick marks the wrap back to digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_reg        <= SEG_OFF;
      dp_reg         <= DP_OFF;
      an_reg         <= AN_OFF;
      frame_tick_reg <= 1'b0;
      active_reg     <= 1'b0;
    end else begin
      if (tick || !active_reg) begin
        seg_reg <= seg_next;
        dp_reg  <= dp_next;
        an_reg  <= an_next;
      end
      frame_tick_reg <= boundary;
      active_reg     <= 1'b1;
    end
  end

  assign bus.seg_out    = seg_reg;
  assign bus.dp_out     = dp_reg;
  assign bus.an_out     = an_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 4-cycle slots, active-low pins).
// Every cycle is compared against a reference model that derives the scan position
// from the edge count and the displayed frame from the load history; on top of that,
// a table of fixed vectors and a few hand-written sequences check constant expectations.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } content_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dpo;    // expected dp_out per digit
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference state: edges since reset release, frame on display, most recent load.
  int       e_cnt = 0;
  content_t shown = '0;
  content_t latest = '0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .SEG_ACTIVE_LOW(1),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pins for digit d of content c, active-low form.
  function automatic void ref_digit(input content_t c, input int d,
                                    output logic [6:0] s, output logic p);
    logic [15:0] upper;
    logic        dark;
    upper = c.value >> (4 * d);
    dark  = c.blank[d] || (d != 0 && c.lz && upper == 16'h0);
    s     = dark ? 7'h7F : seg_tab[c.value[4*d +: 4]];
    p     = c.blank[d] ? 1'b1 : ~c.dp[d];
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cycle();
    logic [6:0] es;
    logic       edp;
    logic [3:0] ean;
    logic       eft;
    int         n;
    int         d;
    logic       bnd;
    @(posedge clk);
    if (!rst_n) begin
      e_cnt  = 0;
      shown  = '0;
      latest = '0;
      es = 7'h7F; edp = 1'b1; ean = 4'hF; eft = 1'b0;
    end else begin
      n   = e_cnt;
      bnd = ((n % RD) == RD - 1) && (((n / RD) % ND) == ND - 1);
      if (bnd) shown = latest;
      if (bus.load) latest = '{bus.value_in, bus.dp_in, bus.blank_in, bus.lz_en};
      d = ((n + 1) / RD) % ND;
      ref_digit(shown, d, es, edp);
      ean    = 4'hF;
      ean[d] = 1'b0;
      eft    = bnd;
      e_cnt++;
    end
    #1;
    chk("seg_out", 16'(bus.seg_out), 16'(es));
    chk("dp_out", 16'(bus.dp_out), 16'(edp));
    chk("an_out", 16'(bus.an_out), 16'(ean));
    chk("frame_tick", 16'(bus.frame_tick), 16'(eft));
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      cycle();
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    chk("frame_wait", 16'(seen), 16'd1);
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.lz_en    = lz;
  endtask

  vec_t tbl [6];

  initial begin
    logic       abcd_seen;
    logic       got_first;
    logic [6:0] first_seg;

    tbl[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111};
    tbl[1] = '{16'h0070, 4'h8, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h0F, 7'h01}, 4'b0111};
    tbl[2] = '{16'hABCD, 4'h5, 4'h2, 1'b0, {7'h08, 7'h60, 7'h7F, 7'h42}, 4'b1010};
    tbl[3] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111};
    tbl[4] = '{16'h89EF, 4'hF, 4'h8, 1'b1, {7'h7F, 7'h04, 7'h30, 7'h38}, 4'b1000};
    tbl[5] = '{16'h0506, 4'h0, 4'h0, 1'b1, {7'h7F, 7'h24, 7'h01, 7'h20}, 4'b1111};

    rst_n    = 1'b0;
    bus.load = 1'b0;
    set_inputs(16'h0, 4'h0, 4'h0, 1'b0);

    // Reset held for three cycles, then release: digit 0 shows "0".
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_seg", 16'(bus.seg_out), 16'h7F);
      chk("rst_dp", 16'(bus.dp_out), 16'h1);
      chk("rst_an", 16'(bus.an_out), 16'hF);
    end
    rst_n = 1'b1;
    cycle();
    chk("release_an", 16'(bus.an_out), 16'hE);
    chk("release_seg", 16'(bus.seg_out), 16'h01);
    $display("reset sequence done");

    // Table: load each vector just after a boundary and check every digit of the next frame.
    wait_frame();
    for (int v = 0; v < 6; v++) begin
      set_inputs(tbl[v].value, tbl[v].dp, tbl[v].blank, tbl[v].lz);
      bus.load = 1'b1;
      cycle();
      bus.load = 1'b0;
      wait_frame();
      for (int k = 0; k < ND; k++) begin
        logic [3:0] ean;
        ean    = 4'hF;
        ean[k] = 1'b0;
        chk("tbl_an", 16'(bus.an_out), 16'(ean));
        chk("tbl_seg", 16'(bus.seg_out), 16'(tbl[v].segs[7*k +: 7]));
        chk("tbl_dp", 16'(bus.dp_out), 16'(tbl[v].dpo[k]));
        for (int c = 0; c < RD; c++) cycle();
      end
      $display("vector %0d value=%h dp=%h blank=%h lz=%0d applied", v, tbl[v].value,
               tbl[v].dp, tbl[v].blank, tbl[v].lz);
    end

    // Double buffer: two loads inside one frame, only the last one is ever shown.
    wait_frame();
    cycle();
    cycle();
    set_inputs(16'hABCD, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    cycle();
    set_inputs(16'h00EF, 4'h0, 4'h0, 1'b1);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    abcd_seen = 1'b0;
    got_first = 1'b0;
    first_seg = 7'h7F;
    for (int i = 0; i < 36; i++) begin
      cycle();
      if ((bus.an_out == 4'hE && bus.seg_out == 7'h42) ||
          (bus.an_out == 4'h7 && bus.seg_out == 7'h08)) abcd_seen = 1'b1;
      if (bus.frame_tick === 1'b1 && !got_first) begin
        got_first = 1'b1;
        first_seg = bus.seg_out;
      end
    end
    chk("dbuf_abcd_hidden", 16'(abcd_seen), 16'h0);
    chk("dbuf_new_d0", 16'(first_seg), 16'h38);
    $display("double-buffer sequence done");

    // Load exactly on a boundary edge: old staging shows now, new data one frame later.
    wait_frame();
    cycle();
    cycle();
    set_inputs(16'h4321, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    set_inputs(16'h5678, 4'h0, 4'h0, 1'b0);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    chk("bnd_tick1", 16'(bus.frame_tick), 16'h1);
    chk("bnd_old_d0", 16'(bus.seg_out), 16'h4F);
    for (int i = 0; i < 16; i++) cycle();
    chk("bnd_tick2", 16'(bus.frame_tick), 16'h1);
    chk("bnd_new_d0", 16'(bus.seg_out), 16'h00);
    $display("boundary-load sequence done");

    // Reset mid-slot, with a load pending that must be dropped.
    cycle();
    set_inputs(16'h9999, 4'hF, 4'h0, 1'b0);
    bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("midrst_an", 16'(bus.an_out), 16'hF);
    chk("midrst_seg", 16'(bus.seg_out), 16'h7F);
    chk("midrst_ft", 16'(bus.frame_tick), 16'h0);
    rst_n = 1'b1;
    cycle();
    chk("midrst_rel_an", 16'(bus.an_out), 16'hE);
    chk("midrst_rel_seg", 16'(bus.seg_out), 16'h01);
    for (int i = 0; i < 20; i++) cycle();
    chk("midrst_drop_seg", 16'(bus.seg_out), 16'h01);
    $display("mid-slot reset sequence done");

    // Randomized traffic: sporadic loads, zero-heavy values, rare resets.
    for (int i = 0; i < 1000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      bus.load = ($urandom_range(0, 5) == 0);
      bus.value_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        bus.value_in = bus.value_in & (16'hFFFF >> (4 * $urandom_range(1, 4)));
      bus.dp_in    = 4'($urandom);
      bus.blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      bus.lz_en    = 1'($urandom);
      cycle();
    end
    rst_n    = 1'b1;
    bus.load = 1'b0;
    $display("random sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
